// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one memory command/response port among num_req_p CCEs,
// with an in-order response queue. Define BP_ME_ARB_LOOPBACK_EN to answer unmapped commands locally.
module bp_me_mem_cmd_arbiter #(
    parameter int          paddr_width_p     = 40,
    parameter int          cce_block_width_p = 512,
    parameter int          lce_id_width_p    = 4,
    parameter int          lce_assoc_p       = 8,
    parameter int          num_req_p         = 2,
    parameter int          max_outstanding_p = 8,
    parameter logic [63:0] mapped_limit_p    = 64'h10_0000_0000,
    localparam int lg_req_lp             = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int lg_depth_lp           = $clog2(max_outstanding_p),
    localparam int cnt_width_lp          = $clog2(max_outstanding_p + 1),
    localparam int cce_mem_hdr_width_lp  = 4 + paddr_width_p + 3 + lce_id_width_p + $clog2(lce_assoc_p),
    localparam int cce_mem_msg_width_lp  = cce_mem_hdr_width_lp + cce_block_width_p
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic [num_req_p*cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic [num_req_p-1:0]                      mem_cmd_v_i,
    output logic [num_req_p-1:0]                      mem_cmd_yumi_o,
    output logic [num_req_p*cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic [num_req_p-1:0]                      mem_resp_v_o,
    input  logic [num_req_p-1:0]                      mem_resp_yumi_i,
    output logic [cce_mem_msg_width_lp-1:0]           mem_cmd_o,
    output logic                                      mem_cmd_v_o,
    input  logic                                      mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0]           mem_resp_i,
    input  logic                                      mem_resp_v_i,
    output logic                                      mem_resp_yumi_o
);

`ifdef BP_ME_ARB_LOOPBACK_EN
    localparam logic loopback_en_lp = 1'b1;
`else
    localparam logic loopback_en_lp = 1'b0;
`endif

    logic [lg_req_lp-1:0]            last_q, last_d;
    logic [cce_mem_msg_width_lp-1:0] cmd_q, cmd_d;
    logic                            cmd_v_q, cmd_v_d;
    logic [lg_depth_lp-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_width_lp-1:0]         cnt_q, cnt_d;
    logic                            q_local_q [max_outstanding_p];
    logic [lg_req_lp-1:0]            q_src_q   [max_outstanding_p];
    logic [cce_mem_hdr_width_lp-1:0] q_hdr_q   [max_outstanding_p];

    logic                            found_s, hit_s, can_issue_s, push_s, pop_s, local_s;
    int unsigned                     scan_idx_s;
    logic [lg_req_lp-1:0]            winner_s, head_src_s;
    logic [cce_mem_msg_width_lp-1:0] win_cmd_s;
    logic [paddr_width_p-1:0]        win_addr_s;

    // Round-robin winner search and issue decision; push is held off during reset.
    always_comb begin
        found_s    = 1'b0;
        hit_s      = 1'b0;
        scan_idx_s = 0;
        winner_s   = last_q;
        for (int k = 1; k <= num_req_p; k++) begin
            scan_idx_s = (int'(last_q) + k) % num_req_p;
            hit_s      = ~found_s & mem_cmd_v_i[scan_idx_s];
            winner_s   = hit_s ? lg_req_lp'(scan_idx_s) : winner_s;
            found_s    = found_s | hit_s;
        end
        can_issue_s = (cnt_q < cnt_width_lp'(max_outstanding_p)) & (~cmd_v_q | mem_cmd_ready_i);
        push_s      = can_issue_s & found_s & reset_n_i;
        win_cmd_s   = mem_cmd_i[int'(winner_s)*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
        win_addr_s  = win_cmd_s[4 +: paddr_width_p];
        local_s     = loopback_en_lp
                      & ({{(64-paddr_width_p){1'b0}}, win_addr_s} >= mapped_limit_p);
        mem_cmd_yumi_o = '0;
        mem_cmd_yumi_o[winner_s] = push_s;
    end

    // Response routing from the order-queue head; forwarded responses pass straight through.
    always_comb begin
        mem_resp_o      = '0;
        mem_resp_v_o    = '0;
        mem_resp_yumi_o = 1'b0;
        pop_s           = 1'b0;
        head_src_s      = q_src_q[rd_ptr_q];
        if (cnt_q != '0) begin
            if (q_local_q[rd_ptr_q]) begin
                mem_resp_o[int'(head_src_s)*cce_mem_msg_width_lp +: cce_mem_msg_width_lp] =
                    {{cce_block_width_p{1'b0}}, q_hdr_q[rd_ptr_q]};
                mem_resp_v_o[head_src_s] = 1'b1;
                pop_s = mem_resp_yumi_i[head_src_s];
            end else begin
                mem_resp_o[int'(head_src_s)*cce_mem_msg_width_lp +: cce_mem_msg_width_lp] = mem_resp_i;
                mem_resp_v_o[head_src_s] = mem_resp_v_i;
                mem_resp_yumi_o = mem_resp_yumi_i[head_src_s] & mem_resp_v_i;
                pop_s = mem_resp_yumi_i[head_src_s] & mem_resp_v_i;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next state for the command register, pointers and occupancy count.
    always_comb begin
        cmd_d   = cmd_q;
        cmd_v_d = cmd_v_q;
        if (push_s & ~local_s) begin
            cmd_d   = win_cmd_s;
            cmd_v_d = 1'b1;
        end else if (cmd_v_q & mem_cmd_ready_i) begin
            cmd_v_d = 1'b0;
        end else begin
            cmd_v_d = cmd_v_q;
        end
        last_d   = push_s ? winner_s : last_q;
        wr_ptr_d = wr_ptr_q + lg_depth_lp'(push_s);
        rd_ptr_d = rd_ptr_q + lg_depth_lp'(pop_s);
        cnt_d    = cnt_q + cnt_width_lp'(push_s) - cnt_width_lp'(pop_s);
    end

    // State registers; reset drops everything in flight and points arbitration at requester 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            last_q   <= lg_req_lp'(num_req_p - 1);
            cmd_q    <= '0;
            cmd_v_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < max_outstanding_p; i++) begin
                q_local_q[i] <= 1'b0;
                q_src_q[i]   <= '0;
                q_hdr_q[i]   <= '0;
            end
        end else begin
            last_q   <= last_d;
            cmd_q    <= cmd_d;
            cmd_v_q  <= cmd_v_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_s) begin
                q_local_q[wr_ptr_q] <= local_s;
                q_src_q[wr_ptr_q]   <= winner_s;
                q_hdr_q[wr_ptr_q]   <= win_cmd_s[cce_mem_hdr_width_lp-1:0];
            end
        end
    end

    assign mem_cmd_o   = cmd_q;
    assign mem_cmd_v_o = cmd_v_q;

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_bp_me_mem_cmd_arbiter;
    localparam int NR = 2;
    localparam int DEPTH = 8;
    localparam int BW = 64;
    localparam int HW = 4 + 40 + 3 + 4 + 3;
    localparam int MW = HW + BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR*MW-1:0] mem_cmd_i = '0;
    logic [NR-1:0]    mem_cmd_v_i = '0;
    logic [NR-1:0]    mem_cmd_yumi_o;
    logic [NR*MW-1:0] mem_resp_o;
    logic [NR-1:0]    mem_resp_v_o;
    logic [NR-1:0]    mem_resp_yumi_i = '0;
    logic [MW-1:0]    mem_cmd_o;
    logic             mem_cmd_v_o;
    logic             mem_cmd_ready_i = 1'b0;
    logic [MW-1:0]    mem_resp_i = '0;
    logic             mem_resp_v_i = 1'b0;
    logic             mem_resp_yumi_o;

    bp_me_mem_cmd_arbiter #(.cce_block_width_p(BW), .num_req_p(NR), .max_outstanding_p(DEPTH)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_yumi_o(mem_cmd_yumi_o),
        .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_yumi_i(mem_resp_yumi_i),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Command: header {payload[7], size[3], addr[40], type[4]} under data[64].
    function automatic logic [MW-1:0] mk(input int r, input int s, input bit big);
        logic [39:0] a;
        logic [HW-1:0] h;
        logic [BW-1:0] d;
        a = big ? (40'h20_0000_0000 + 40'(s)) : {8'(r), 32'(s * 64)};
        h = {7'(s), 3'h3, a, 4'(r + 1)};
        d = {32'hDA7A_0000 | 32'(r), 32'(s)};
        return {d, h};
    endfunction

    // Reference model state
    typedef struct { bit loc; int src; logic [HW-1:0] hdr; } ent_t;
    ent_t oq[$];
    bit held_v = 0;
    logic [MW-1:0] held_cmd = '0;
    int last_m = NR - 1;
    int seq[NR] = '{0, 0};
    bit big[NR] = '{0, 0};
    int acc_log[$], acc_cyc[$], pop_log[$], pop_cyc[$];
    int cyc = 0;

    ent_t hd;
    int win, ex_src;
    bit acc, popm, loc;
    logic [NR-1:0] ex_yumi, ex_rv;
    logic ex_ry;
    logic [MW-1:0] ex_slice, c;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            oq.delete();
            held_v = 0;
            last_m = NR - 1;
            chk("rst_cmd_v", 128'(mem_cmd_v_o), 128'd0);
            chk("rst_cmd_yumi", 128'(mem_cmd_yumi_o), 128'd0);
            chk("rst_resp_v", 128'(mem_resp_v_o), 128'd0);
            chk("rst_resp_yumi", 128'(mem_resp_yumi_o), 128'd0);
        end else begin
            win = -1;
            for (int k = 1; k <= NR; k++) begin
                int r;
                r = (last_m + k) % NR;
                if (win < 0 && mem_cmd_v_i[r]) win = r;
            end
            acc = (oq.size() < DEPTH) && (!held_v || mem_cmd_ready_i) && (win >= 0);
            ex_yumi = '0;
            if (acc) ex_yumi[win] = 1'b1;
            ex_rv = '0; ex_ry = 1'b0; popm = 0; ex_src = -1; ex_slice = '0;
            if (oq.size() > 0) begin
                hd = oq[0];
                ex_src = hd.src;
                if (hd.loc) begin
                    ex_rv[hd.src] = 1'b1;
                    ex_slice = {{BW{1'b0}}, hd.hdr};
                    popm = mem_resp_yumi_i[hd.src];
                end else begin
                    ex_rv[hd.src] = mem_resp_v_i;
                    ex_slice = mem_resp_i;
                    ex_ry = mem_resp_yumi_i[hd.src] & mem_resp_v_i;
                    popm = ex_ry;
                end
            end
            chk("cmd_yumi", 128'(mem_cmd_yumi_o), 128'(ex_yumi));
            chk("cmd_v", 128'(mem_cmd_v_o), 128'(held_v));
            if (held_v) chk("cmd_data", 128'(mem_cmd_o), 128'(held_cmd));
            chk("resp_v", 128'(mem_resp_v_o), 128'(ex_rv));
            chk("resp_yumi", 128'(mem_resp_yumi_o), 128'(ex_ry));
            if (ex_rv != '0) chk("resp_data", 128'(mem_resp_o[ex_src*MW +: MW]), 128'(ex_slice));
            if (popm) begin
                void'(oq.pop_front());
                pop_log.push_back(ex_src);
                pop_cyc.push_back(cyc);
            end
            if (acc) begin
                c = mem_cmd_i[win*MW +: MW];
`ifdef BP_ME_ARB_LOOPBACK_EN
                loc = (c[4 +: 40] >= 40'h10_0000_0000);
`else
                loc = 0;
`endif
                oq.push_back('{loc, win, c[HW-1:0]});
                acc_log.push_back(win);
                acc_cyc.push_back(cyc);
                seq[win]++;
                last_m = win;
                if (!loc) begin
                    held_cmd = c;
                    held_v = 1;
                end else if (mem_cmd_ready_i) held_v = 0;
            end else if (mem_cmd_ready_i) held_v = 0;
        end
    end

    task automatic drive_cmds();
        for (int r = 0; r < NR; r++) mem_cmd_i[r*MW +: MW] = mk(r, seq[r], big[r]);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            drive_cmds();
            @(posedge clk);
            #1;
        end
        drive_cmds();
    endtask

    task automatic set_resp(input logic v, input logic [NR-1:0] y);
        mem_resp_v_i = v;
        mem_resp_yumi_i = y;
    endtask

    logic [MW-1:0] tag_a, tag_b, exp_msg;
    int s0, sb;

    initial begin
        tick(2);
        rst_n = 1'b1;
        mem_cmd_ready_i = 1'b1;
        mem_resp_i = {64'hFEED_0000_0000_0001, 54'h1};

        // Fairness: both requesters always valid.
        acc_log.delete(); pop_log.delete();
        mem_cmd_v_i = 2'b11;
        tick(6);
        mem_cmd_v_i = 2'b00;
        chk("fair_count", 128'(acc_log.size()), 128'd6);
        for (int i = 0; i < 6; i++) chk("fair_order", 128'(acc_log[i]), 128'(i % 2));
        set_resp(1'b1, 2'b11);
        tick(6);
        set_resp(1'b0, 2'b00);
        for (int i = 0; i < 6; i++) chk("fair_resp_order", 128'(pop_log[i]), 128'(i % 2));

        // Fill to full, then free one slot.
        acc_log.delete(); acc_cyc.delete(); pop_cyc.delete();
        mem_cmd_v_i = 2'b01;
        tick(11);
        chk("full_count", 128'(acc_log.size()), 128'd8);
        #1 chk("full_stall", 128'(mem_cmd_yumi_o), 128'd0);
        set_resp(1'b1, 2'b01);
        tick(1);
        set_resp(1'b0, 2'b00);
        tick(2);
        chk("full_ninth", 128'(acc_log.size()), 128'd9);
        chk("full_ninth_cycle", 128'(acc_cyc[8]), 128'(pop_cyc[0] + 1));
        mem_cmd_v_i = 2'b00;
        set_resp(1'b1, 2'b11);
        tick(8);
        set_resp(1'b0, 2'b00);

        // Order: A from req0, B from req1.
        mem_cmd_v_i = 2'b01; tick(1);
        mem_cmd_v_i = 2'b10; tick(1);
        mem_cmd_v_i = 2'b00; tick(1);
        tag_a = {64'hAAAA_0000_0000_000A, 54'hA};
        tag_b = {64'hBBBB_0000_0000_000B, 54'hB};
        mem_resp_i = tag_a;
        set_resp(1'b1, 2'b01);
        #1;
        chk("order_a_v", 128'(mem_resp_v_o), 128'd1);
        chk("order_a_data", 128'(mem_resp_o[0 +: MW]), 128'(tag_a));
        chk("order_a_yumi", 128'(mem_resp_yumi_o), 128'd1);
        tick(1);
        mem_resp_i = tag_b;
        set_resp(1'b1, 2'b10);
        #1;
        chk("order_b_v", 128'(mem_resp_v_o), 128'd2);
        chk("order_b_data", 128'(mem_resp_o[MW +: MW]), 128'(tag_b));
        chk("order_b_yumi", 128'(mem_resp_yumi_o), 128'd1);
        tick(1);
        set_resp(1'b0, 2'b00);

        // Backpressure.
        acc_log.delete();
        mem_cmd_ready_i = 1'b0;
        mem_cmd_v_i = 2'b01;
        s0 = seq[0];
        tick(1);
        exp_msg = mk(0, s0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_data", 128'(mem_cmd_o), 128'(exp_msg));
            chk("bp_no_yumi", 128'(mem_cmd_yumi_o), 128'd0);
            tick(1);
        end
        chk("bp_count", 128'(acc_log.size()), 128'd1);
        mem_cmd_ready_i = 1'b1;
        #1 chk("bp_resume_yumi", 128'(mem_cmd_yumi_o), 128'd1);
        tick(1);
        mem_cmd_v_i = 2'b00;
        exp_msg = mk(0, s0 + 1, 0);
        chk("bp_next_data", 128'(mem_cmd_o), 128'(exp_msg));
        chk("bp_next_v", 128'(mem_cmd_v_o), 128'd1);
        tick(1);
        set_resp(1'b1, 2'b11);
        tick(2);
        set_resp(1'b0, 2'b00);

        // Unmapped address behind an outstanding forwarded command.
        s0 = seq[0];
        mem_cmd_v_i = 2'b01; tick(1);
        sb = seq[1];
        big[1] = 1'b1;
        mem_cmd_v_i = 2'b10; tick(1);
        mem_cmd_v_i = 2'b00;
`ifdef BP_ME_ARB_LOOPBACK_EN
        exp_msg = mk(0, s0, 0);
        chk("lb_cmd_not_sent", 128'(mem_cmd_o), 128'(exp_msg));
        tick(1);
        #1 chk("lb_held_back", 128'(mem_resp_v_o), 128'd0);
        set_resp(1'b1, 2'b01);
        tick(1);
        set_resp(1'b0, 2'b00);
        #1;
        exp_msg = mk(1, sb, 1);
        exp_msg = {{BW{1'b0}}, exp_msg[HW-1:0]};
        chk("lb_resp_v", 128'(mem_resp_v_o), 128'd2);
        chk("lb_resp_data", 128'(mem_resp_o[MW +: MW]), 128'(exp_msg));
        chk("lb_no_down_yumi", 128'(mem_resp_yumi_o), 128'd0);
        mem_resp_yumi_i = 2'b10;
        tick(1);
        mem_resp_yumi_i = 2'b00;
`else
        exp_msg = mk(1, sb, 1);
        chk("lb_off_forwarded", 128'(mem_cmd_o), 128'(exp_msg));
        tick(1);
        set_resp(1'b1, 2'b11);
        tick(2);
        set_resp(1'b0, 2'b00);
`endif
        big[1] = 1'b0;
        tick(1);

        // Reset with three entries queued.
        mem_cmd_v_i = 2'b01;
        tick(3);
        mem_cmd_v_i = 2'b11;
        mem_resp_v_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_v", 128'(mem_cmd_v_o), 128'd0);
        chk("mid_rst_cmd_yumi", 128'(mem_cmd_yumi_o), 128'd0);
        chk("mid_rst_resp_v", 128'(mem_resp_v_o), 128'd0);
        chk("mid_rst_resp_yumi", 128'(mem_resp_yumi_o), 128'd0);
        tick(2);
        mem_resp_v_i = 1'b0;
        rst_n = 1'b1;
        acc_log.delete();
        #1 chk("post_rst_yumi", 128'(mem_cmd_yumi_o), 128'd1);
        tick(1);
        chk("post_rst_first", 128'(acc_log[0]), 128'd0);
        mem_cmd_v_i = 2'b00;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
